// File: rtl/cp0_tlb_ext_if.sv
// CP0 register-file bus: MTC0/MFC0 access, exception/ERET commit,
// TLB instruction results and the TLB/architectural register views.
`timescale 1ns/1ps
interface cp0_tlb_ext_if #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
);
    logic             we;
    logic [4:0]       waddr;
    logic [4:0]       raddr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic [5:0]       int_i;
    logic             exc_valid;
    logic [4:0]       exc_code;
    logic [31:0]      exc_pc;
    logic             in_delayslot;
    logic [31:0]      bad_vaddr;
    logic             eret;
    logic [1:0]       tlb_op;
    logic [31:0]      tlbr_hi;
    logic [31:0]      tlbr_lo0;
    logic [31:0]      tlbr_lo1;
    logic [31:0]      tlbr_mask;
    logic             tlbp_hit;
    logic [IDX_W-1:0] tlbp_idx;
    logic [31:0]      index_o;
    logic [31:0]      random_o;
    logic [31:0]      entryhi_o;
    logic [31:0]      entrylo0_o;
    logic [31:0]      entrylo1_o;
    logic [31:0]      pagemask_o;
    logic [31:0]      status_o;
    logic [31:0]      cause_o;
    logic [31:0]      epc_o;
    logic             int_req;

    // Pipeline side
    modport master (
        output we, waddr, raddr, wdata, int_i, exc_valid, exc_code, exc_pc,
               in_delayslot, bad_vaddr, eret, tlb_op, tlbr_hi, tlbr_lo0,
               tlbr_lo1, tlbr_mask, tlbp_hit, tlbp_idx,
        input  rdata, index_o, random_o, entryhi_o, entrylo0_o, entrylo1_o,
               pagemask_o, status_o, cause_o, epc_o, int_req
    );

    // CP0 side
    modport slave (
        input  we, waddr, raddr, wdata, int_i, exc_valid, exc_code, exc_pc,
               in_delayslot, bad_vaddr, eret, tlb_op, tlbr_hi, tlbr_lo0,
               tlbr_lo1, tlbr_mask, tlbp_hit, tlbp_idx,
        output rdata, index_o, random_o, entryhi_o, entrylo0_o, entrylo1_o,
               pagemask_o, status_o, cause_o, epc_o, int_req
    );
endinterface

// File: rtl/cp0_tlb_ext.sv
// MIPS-style CP0 with TLB support registers, Count/Compare timer,
// exception/ERET bookkeeping and a Wired-bounded Random counter.
`timescale 1ns/1ps
module cp0_tlb_ext #(
    parameter int          TLB_ENTRIES = 16,
    parameter int          COUNT_DIV   = 2,
    parameter logic [31:0] PRID_VAL    = 32'h00004C02
) (
    input logic        clk,
    input logic        rst,
    cp0_tlb_ext_if.slave bus
);
    localparam int IDX_W = $clog2(TLB_ENTRIES);
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(TLB_ENTRIES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    localparam logic [31:0] IDX_MASK    = 32'(TLB_ENTRIES - 1);
    localparam logic [31:0] LO_MASK     = 32'h03FFFFFF;
    localparam logic [31:0] PM_MASK     = 32'h01FFE000;
    localparam logic [31:0] HI_MASK     = 32'hFFFFE0FF;
    localparam logic [31:0] STATUS_MASK = 32'h0000FF03;
    localparam logic [31:0] CAUSE_MASK  = 32'h00000300;
    localparam logic [31:0] STATUS_BEV  = 32'h00400000;
    localparam logic [31:0] CONFIG_VAL  = 32'h00008000;

    localparam logic [4:0] R_INDEX    = 5'd0;
    localparam logic [4:0] R_RANDOM   = 5'd1;
    localparam logic [4:0] R_ENTRYLO0 = 5'd2;
    localparam logic [4:0] R_ENTRYLO1 = 5'd3;
    localparam logic [4:0] R_PAGEMASK = 5'd5;
    localparam logic [4:0] R_WIRED    = 5'd6;
    localparam logic [4:0] R_BADVADDR = 5'd8;
    localparam logic [4:0] R_COUNT    = 5'd9;
    localparam logic [4:0] R_ENTRYHI  = 5'd10;
    localparam logic [4:0] R_COMPARE  = 5'd11;
    localparam logic [4:0] R_STATUS   = 5'd12;
    localparam logic [4:0] R_CAUSE    = 5'd13;
    localparam logic [4:0] R_EPC      = 5'd14;
    localparam logic [4:0] R_PRID     = 5'd15;
    localparam logic [4:0] R_CONFIG   = 5'd16;

    typedef enum logic [1:0] {TLB_NONE = 2'b00, TLB_R = 2'b01, TLB_P = 2'b10, TLB_WR = 2'b11} tlb_op_e;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    logic [31:0] index_q, entryhi_q, entrylo0_q, entrylo1_q, pagemask_q;
    logic [31:0] badvaddr_q, count_q, compare_q, status_q, cause_q, epc_q;
    logic [31:0] index_d, entryhi_d, entrylo0_d, entrylo1_d, pagemask_d;
    logic [31:0] badvaddr_d, count_d, compare_d, status_d, cause_d, epc_d;
    logic [IDX_W-1:0] random_q, wired_q, random_d, wired_d;
    logic [DIV_W-1:0] div_q, div_d;

    logic act_exc, act_eret, act_tlbr, act_tlbp;
    logic code_addr, code_tlb, exl, tick, ti_d;

    // Arbitrate the winning action and compute every register's next value
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        index_d    = index_q;
        entryhi_d  = entryhi_q;
        entrylo0_d = entrylo0_q;
        entrylo1_d = entrylo1_q;
        pagemask_d = pagemask_q;
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        wired_d    = wired_q;
        random_d   = random_q;
        div_d      = div_q;

        act_exc   = bus.exc_valid;
        act_eret  = !bus.exc_valid && bus.eret;
        act_tlbr  = !bus.exc_valid && !bus.eret && (bus.tlb_op == TLB_R);
        act_tlbp  = !bus.exc_valid && !bus.eret && (bus.tlb_op == TLB_P);
        code_addr = (bus.exc_code >= 5'd1) && (bus.exc_code <= 5'd5);
        code_tlb  = (bus.exc_code >= 5'd1) && (bus.exc_code <= 5'd3);
        exl       = status_q[1];
        tick      = (div_q == DIV_LAST);

        // Count and its prescaler; a software write restarts the prescaler
        if (bus.we && bus.waddr == R_COUNT) begin
            count_d = bus.wdata;
            div_d   = '0;
        end else if (tick) begin
            count_d = count_q + 32'd1;
            div_d   = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        // Timer interrupt: set when Count steps onto Compare, cleared by a Compare write
        if (bus.we && bus.waddr == R_COMPARE) begin
            compare_d = bus.wdata;
            ti_d      = 1'b0;
        end else if (tick && !(bus.we && bus.waddr == R_COUNT) && (count_q + 32'd1 == compare_q)) begin
            ti_d = 1'b1;
        end else begin
            ti_d = cause_q[30];
        end

        cause_d[30]    = ti_d;
        cause_d[15:10] = {bus.int_i[5] | cause_q[30], bus.int_i[4:0]};
        if (act_exc) begin
            cause_d[6:2] = bus.exc_code;
            if (!exl)
                cause_d[31] = bus.in_delayslot;
        end else if (bus.we && bus.waddr == R_CAUSE) begin
            cause_d = merge(cause_d, bus.wdata, CAUSE_MASK);
        end

        if (act_exc)
            status_d[1] = 1'b1;
        else if (act_eret)
            status_d[1] = 1'b0;
        else if (bus.we && bus.waddr == R_STATUS)
            status_d = merge(status_q, bus.wdata, STATUS_MASK);
        status_d = status_d | STATUS_BEV;

        if (act_exc) begin
            if (!exl)
                epc_d = bus.in_delayslot ? bus.exc_pc - 32'd4 : bus.exc_pc;
        end else if (bus.we && bus.waddr == R_EPC) begin
            epc_d = bus.wdata;
        end

        if (act_exc && code_addr)
            badvaddr_d = bus.bad_vaddr;

        // Registers below are untouched by ERET, so MTC0 falls through to them
        if (act_exc && code_tlb)
            entryhi_d = {bus.bad_vaddr[31:13], entryhi_q[12:0]};
        else if (act_tlbr)
            entryhi_d = bus.tlbr_hi & HI_MASK;
        else if (bus.we && bus.waddr == R_ENTRYHI)
            entryhi_d = merge(entryhi_q, bus.wdata, HI_MASK);

        if (act_tlbr) begin
            entrylo0_d = bus.tlbr_lo0 & LO_MASK;
            entrylo1_d = bus.tlbr_lo1 & LO_MASK;
            pagemask_d = bus.tlbr_mask & PM_MASK;
        end else begin
            if (bus.we && bus.waddr == R_ENTRYLO0)
                entrylo0_d = merge(entrylo0_q, bus.wdata, LO_MASK);
            if (bus.we && bus.waddr == R_ENTRYLO1)
                entrylo1_d = merge(entrylo1_q, bus.wdata, LO_MASK);
            if (bus.we && bus.waddr == R_PAGEMASK)
                pagemask_d = merge(pagemask_q, bus.wdata, PM_MASK);
        end

        if (act_tlbp)
            index_d = bus.tlbp_hit ? 32'(bus.tlbp_idx) : 32'h80000000;
        else if (bus.we && bus.waddr == R_INDEX)
            index_d = merge(index_q, bus.wdata, IDX_MASK);

        // Random walks down to Wired then wraps; a Wired write restarts it at the top
        if (bus.we && bus.waddr == R_WIRED) begin
            wired_d  = bus.wdata[IDX_W-1:0];
            random_d = TOP_IDX;
        end else if ((random_q == wired_q) || (random_q == TOP_IDX && wired_q >= TOP_IDX)) begin
            random_d = TOP_IDX;
        end else begin
            random_d = random_q - IDX_W'(1);
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q    <= '0;
            entryhi_q  <= '0;
            entrylo0_q <= '0;
            entrylo1_q <= '0;
            pagemask_q <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            status_q   <= STATUS_BEV;
            cause_q    <= '0;
            epc_q      <= '0;
            wired_q    <= '0;
            random_q   <= TOP_IDX;
            div_q      <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            index_q    <= index_d;
            entryhi_q  <= entryhi_d;
            entrylo0_q <= entrylo0_d;
            entrylo1_q <= entrylo1_d;
            pagemask_q <= pagemask_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            wired_q    <= wired_d;
            random_q   <= random_d;
            div_q      <= div_d;
        end
    end

    // MFC0 read decode, combinational from current register state
    always_comb begin
        bus.rdata = 32'h0;
        case (bus.raddr)
            R_INDEX:    bus.rdata = index_q;
            R_RANDOM:   bus.rdata = 32'(random_q);
            R_ENTRYLO0: bus.rdata = entrylo0_q;
            R_ENTRYLO1: bus.rdata = entrylo1_q;
            R_PAGEMASK: bus.rdata = pagemask_q;
            R_WIRED:    bus.rdata = 32'(wired_q);
            R_BADVADDR: bus.rdata = badvaddr_q;
            R_COUNT:    bus.rdata = count_q;
            R_ENTRYHI:  bus.rdata = entryhi_q;
            R_COMPARE:  bus.rdata = compare_q;
            R_STATUS:   bus.rdata = status_q;
            R_CAUSE:    bus.rdata = cause_q;
            R_EPC:      bus.rdata = epc_q;
            R_PRID:     bus.rdata = PRID_VAL;
            R_CONFIG:   bus.rdata = CONFIG_VAL;
            default:    bus.rdata = 32'h0;
        endcase
    end

    assign bus.index_o    = index_q;
    assign bus.random_o   = 32'(random_q);
    assign bus.entryhi_o  = entryhi_q;
    assign bus.entrylo0_o = entrylo0_q;
    assign bus.entrylo1_o = entrylo1_q;
    assign bus.pagemask_o = pagemask_q;
    assign bus.status_o   = status_q;
    assign bus.cause_o    = cause_q;
    assign bus.epc_o      = epc_q;
    assign bus.int_req    = status_q[0] & ~status_q[1] & |(cause_q[15:8] & status_q[15:8]);
endmodule

// File: tb/tb_cp0_tlb_ext.sv
// Self-checking bench for cp0_tlb_ext: register table plus timer,
// exception, Random, TLB-instruction, priority and reset sequences.
`timescale 1ns/1ps
module tb_cp0_tlb_ext;
    localparam int N   = 16;
    localparam int DIV = 2;

    localparam int S_INTREQ = 32;
    localparam int S_RANDOM = 33;
    localparam int S_INDEX  = 34;
    localparam int S_HI     = 35;
    localparam int S_LO0    = 36;
    localparam int S_LO1    = 37;
    localparam int S_PMASK  = 38;
    localparam int S_STATUS = 39;
    localparam int S_CAUSE  = 40;
    localparam int S_EPC    = 41;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #50 clk = ~clk;

    cp0_tlb_ext_if #(.TLB_ENTRIES(N)) bus ();
    cp0_tlb_ext #(.TLB_ENTRIES(N), .COUNT_DIV(DIV), .PRID_VAL(32'h00004C02)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    typedef struct {
        string       name;
        logic [4:0]  reg_n;
        logic [31:0] wdata;
        int          sel;
        logic [31:0] exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_sel(input int sel, output logic [31:0] v);
        if (sel < 32) begin
            bus.raddr = 5'(sel);
            #1;
            v = bus.rdata;
        end else begin
            case (sel)
                S_INTREQ: v = {31'b0, bus.int_req};
                S_RANDOM: v = bus.random_o;
                S_INDEX:  v = bus.index_o;
                S_HI:     v = bus.entryhi_o;
                S_LO0:    v = bus.entrylo0_o;
                S_LO1:    v = bus.entrylo1_o;
                S_PMASK:  v = bus.pagemask_o;
                S_STATUS: v = bus.status_o;
                S_CAUSE:  v = bus.cause_o;
                S_EPC:    v = bus.epc_o;
                default:  v = 'x;
            endcase
        end
    endtask

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] a;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            read_sel(e.sel, a);
            check(e.name, a, e.exp);
        end
    endtask

    task automatic idle_inputs();
        bus.we = 0; bus.waddr = 0; bus.raddr = 0; bus.wdata = 0; bus.int_i = 0;
        bus.exc_valid = 0; bus.exc_code = 0; bus.exc_pc = 0; bus.in_delayslot = 0;
        bus.bad_vaddr = 0; bus.eret = 0; bus.tlb_op = 2'b00;
        bus.tlbr_hi = 0; bus.tlbr_lo0 = 0; bus.tlbr_lo1 = 0; bus.tlbr_mask = 0;
        bus.tlbp_hit = 0; bus.tlbp_idx = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        bus.we = 1; bus.waddr = r; bus.wdata = d;
        tick();
        bus.we = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int r;
        vecs.push_back('{"index_mask",   5'd0,  32'hFFFFFFFF, 0,  32'h0000000F});
        vecs.push_back('{"lo0_mask",     5'd2,  32'hFFFFFFFF, 2,  32'h03FFFFFF});
        vecs.push_back('{"lo1_mask",     5'd3,  32'hA5A5A5A5, 3,  32'h01A5A5A5});
        vecs.push_back('{"pagemask",     5'd5,  32'hFFFFFFFF, 5,  32'h01FFE000});
        vecs.push_back('{"entryhi_mask", 5'd10, 32'hFFFFFFFF, 10, 32'hFFFFE0FF});
        vecs.push_back('{"wired_mask",   5'd6,  32'hFFFFFFFF, 6,  32'h0000000F});
        vecs.push_back('{"random_pin",   5'd6,  32'hFFFFFFFF, 1,  32'h0000000F});
        vecs.push_back('{"wired_4",      5'd6,  32'h00000004, 6,  32'h00000004});
        vecs.push_back('{"wired_0_rand", 5'd6,  32'h00000000, 1,  32'h0000000F});
        vecs.push_back('{"badvaddr_ro",  5'd8,  32'hFFFFFFFF, 8,  32'h00000000});
        vecs.push_back('{"count_load",   5'd9,  32'd100,      9,  32'd100});
        vecs.push_back('{"compare",      5'd11, 32'hABCD0000, 11, 32'hABCD0000});
        vecs.push_back('{"status_all",   5'd12, 32'hFFFFFFFF, 12, 32'h0040FF03});
        vecs.push_back('{"status_clr",   5'd12, 32'h00000000, 12, 32'h00400000});
        vecs.push_back('{"cause_mask",   5'd13, 32'hFFFFFFFF, 13, 32'h00000300});
        vecs.push_back('{"cause_clr",    5'd13, 32'h00000000, 13, 32'h00000000});
        vecs.push_back('{"epc",          5'd14, 32'h12345678, 14, 32'h12345678});
        vecs.push_back('{"prid_ro",      5'd15, 32'hFFFFFFFF, 15, 32'h00004C02});
        vecs.push_back('{"config_ro",    5'd16, 32'h00000000, 16, 32'h00008000});
        vecs.push_back('{"unmapped_4",   5'd4,  32'hFFFFFFFF, 4,  32'h00000000});
        vecs.push_back('{"index_port",   5'd0,  32'h00000003, S_INDEX, 32'h00000003});

        // Reset values
        do_reset();
        expect_val("rst_index", 0, 32'h0);
        expect_val("rst_random", 1, 32'd15);
        expect_val("rst_lo0", 2, 32'h0);
        expect_val("rst_lo1", 3, 32'h0);
        expect_val("rst_pagemask", 5, 32'h0);
        expect_val("rst_wired", 6, 32'h0);
        expect_val("rst_badvaddr", 8, 32'h0);
        expect_val("rst_count", 9, 32'h0);
        expect_val("rst_entryhi", 10, 32'h0);
        expect_val("rst_compare", 11, 32'h0);
        expect_val("rst_status", 12, 32'h00400000);
        expect_val("rst_cause", 13, 32'h0);
        expect_val("rst_epc", 14, 32'h0);
        expect_val("rst_prid", 15, 32'h00004C02);
        expect_val("rst_config", 16, 32'h00008000);
        expect_val("rst_int_req", S_INTREQ, 32'h0);
        drain();

        // Write masks and read decode
        foreach (vecs[i]) begin
            mtc0(vecs[i].reg_n, vecs[i].wdata);
            expect_val(vecs[i].name, vecs[i].sel, vecs[i].exp);
            drain();
        end

        // Timer: Compare=5, Count=0, divider 2
        do_reset();
        mtc0(5'd11, 32'd5);
        mtc0(5'd12, 32'h00008001);
        mtc0(5'd9, 32'd0);
        for (int i = 1; i <= DIV * 5; i++) begin
            tick();
            if (i == DIV * 5 - 1) begin
                expect_val("ti_not_yet", 13, 32'h00000000);
                drain();
            end
        end
        expect_val("ti_set", 13, 32'h40000000);
        expect_val("int_req_lag", S_INTREQ, 32'h0);
        drain();
        tick();
        expect_val("ip7_set", 13, 32'h40008000);
        expect_val("int_req_on", S_INTREQ, 32'h1);
        drain();
        mtc0(5'd11, 32'd200);
        expect_val("ti_cleared", 13, 32'h00008000);
        drain();
        tick();
        expect_val("ip7_cleared", S_CAUSE, 32'h00000000);
        expect_val("int_req_off", S_INTREQ, 32'h0);
        drain();

        // Exceptions
        do_reset();
        bus.exc_valid = 1; bus.exc_code = 5'd2; bus.exc_pc = 32'h80001004;
        bus.in_delayslot = 1; bus.bad_vaddr = 32'h00403ABC;
        tick();
        bus.exc_valid = 0;
        expect_val("exc1_epc", S_EPC, 32'h80001000);
        expect_val("exc1_cause", 13, 32'h80000008);
        expect_val("exc1_badv", 8, 32'h00403ABC);
        expect_val("exc1_entryhi", S_HI, 32'h00402000);
        expect_val("exc1_status", S_STATUS, 32'h00400002);
        drain();
        bus.exc_valid = 1; bus.exc_code = 5'd4; bus.exc_pc = 32'h90000000;
        bus.in_delayslot = 0; bus.bad_vaddr = 32'h11112222;
        tick();
        bus.exc_valid = 0;
        expect_val("exc2_epc_kept", 14, 32'h80001000);
        expect_val("exc2_cause", 13, 32'h80000010);
        expect_val("exc2_badv", 8, 32'h11112222);
        expect_val("exc2_entryhi_kept", 10, 32'h00402000);
        drain();
        bus.eret = 1;
        tick();
        bus.eret = 0;
        expect_val("eret_status", 12, 32'h00400000);
        drain();
        bus.exc_valid = 1; bus.exc_code = 5'd0; bus.exc_pc = 32'h80002000; bus.bad_vaddr = 32'h0;
        tick();
        bus.exc_valid = 0;
        expect_val("exc3_epc", 14, 32'h80002000);
        expect_val("exc3_cause", 13, 32'h00000000);
        expect_val("exc3_badv_kept", 8, 32'h11112222);
        drain();

        // Random walk with Wired=4
        do_reset();
        mtc0(5'd6, 32'd4);
        expect_val("rand_restart", S_RANDOM, 32'd15);
        drain();
        r = 15;
        for (int i = 0; i < 14; i++) begin
            tick();
            r = (r == 4) ? 15 : r - 1;
            expect_val($sformatf("rand_step%0d", i), S_RANDOM, 32'(r));
            if (i == 10)
                expect_val("rand_reg_wrap", 1, 32'(r));
            drain();
        end

        // TLB instructions
        do_reset();
        bus.tlb_op = 2'b10; bus.tlbp_hit = 0;
        tick();
        expect_val("tlbp_miss", 0, 32'h80000000);
        drain();
        bus.tlbp_hit = 1; bus.tlbp_idx = 4'd7;
        tick();
        expect_val("tlbp_hit", S_INDEX, 32'h00000007);
        drain();
        bus.tlb_op = 2'b01;
        bus.tlbr_hi = 32'hFFFFFFFF; bus.tlbr_lo0 = 32'hFFFFFFFF;
        bus.tlbr_lo1 = 32'hA5A5A5A5; bus.tlbr_mask = 32'hFFFFFFFF;
        bus.we = 1; bus.waddr = 5'd10; bus.wdata = 32'h00001000;
        tick();
        bus.we = 0;
        expect_val("tlbr_hi", 10, 32'hFFFFE0FF);
        expect_val("tlbr_lo0", S_LO0, 32'h03FFFFFF);
        expect_val("tlbr_lo1", S_LO1, 32'h01A5A5A5);
        expect_val("tlbr_mask", S_PMASK, 32'h01FFE000);
        drain();
        bus.tlb_op = 2'b10; bus.tlbp_hit = 1; bus.tlbp_idx = 4'd2;
        bus.we = 1; bus.waddr = 5'd2; bus.wdata = 32'h00000055;
        tick();
        expect_val("tlbp_idx2", 0, 32'h00000002);
        expect_val("tlbp_mtc0_lo0", 2, 32'h00000055);
        drain();
        bus.tlb_op = 2'b11; bus.waddr = 5'd0; bus.wdata = 32'h00000005;
        tick();
        bus.we = 0; bus.tlb_op = 2'b00;
        expect_val("tlbwr_mtc0_index", 0, 32'h00000005);
        expect_val("tlbwr_hi_kept", 10, 32'hFFFFE0FF);
        drain();

        // Priority: exception beats ERET and MTC0 Status
        do_reset();
        mtc0(5'd14, 32'hCAFE0000);
        bus.exc_valid = 1; bus.exc_code = 5'd8; bus.exc_pc = 32'h80004000; bus.eret = 1;
        bus.we = 1; bus.waddr = 5'd12; bus.wdata = 32'h0000FF01;
        tick();
        bus.eret = 0;
        expect_val("prio_status", 12, 32'h00400002);
        expect_val("prio_epc", 14, 32'h80004000);
        drain();
        bus.exc_pc = 32'h80009000; bus.waddr = 5'd11; bus.wdata = 32'h00000077;
        tick();
        bus.exc_valid = 0; bus.we = 0;
        expect_val("prio_compare_commit", 11, 32'h00000077);
        expect_val("prio_epc_kept", 14, 32'h80004000);
        drain();

        // Asynchronous reset in mid-count
        mtc0(5'd9, 32'd1000);
        tick();
        tick();
        #20;
        rst = 1'b1;
        #5;
        expect_val("arst_count", 9, 32'h0);
        expect_val("arst_random", S_RANDOM, 32'd15);
        expect_val("arst_status", 12, 32'h00400000);
        expect_val("arst_epc", 14, 32'h0);
        expect_val("arst_cause", 13, 32'h0);
        expect_val("arst_compare", 11, 32'h0);
        expect_val("arst_index", 0, 32'h0);
        expect_val("arst_entryhi", 10, 32'h0);
        expect_val("arst_int_req", S_INTREQ, 32'h0);
        drain();
        tick();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
